// File: rtl/trap_pkg.sv
// trap_pkg: shared state encoding, CSR addresses and cause layout for the trap sequencer.
// Rev 1.0
`default_nettype none

package trap_pkg;

   localparam int unsigned TRAP_XLEN     = 32;
   localparam int unsigned CAUSE_INT_BIT = TRAP_XLEN - 1;

   localparam logic [11:0] MEPC   = 12'h341;
   localparam logic [11:0] MCAUSE = 12'h342;
   localparam logic [11:0] MTVAL  = 12'h343;
   localparam logic [11:0] MTVEC  = 12'h305;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_W_EPC   = 3'd1,
      ST_W_CAUSE = 3'd2,
      ST_W_TVAL  = 3'd3,
      ST_RD_TVEC = 3'd4,
      ST_RD_EPC  = 3'd5
   } trap_state_e;

endpackage

`default_nettype wire

// File: rtl/mod_trap_sequencer_if.sv
// mod_trap_sequencer_if: requester, pipeline CSR path, CSR file ports and redirect of the trap sequencer.
// Rev 1.0
`default_nettype none

interface mod_trap_sequencer_if #(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
);
   logic              trap_req_i;
   logic [XLEN-1:0]   trap_pc_i;
   logic [XLEN-1:0]   trap_cause_i;
   logic [XLEN-1:0]   trap_tval_i;
   logic              trap_ack_o;
   logic              mret_req_i;
   logic              mret_ack_o;
   logic              pipe_csr_req_i;
   logic              pipe_csr_we_i;
   logic [CSR_AW-1:0] pipe_csr_raddr_i;
   logic [CSR_AW-1:0] pipe_csr_waddr_i;
   logic [XLEN-1:0]   pipe_csr_wdata_i;
   logic              pipe_csr_gnt_o;
   logic [XLEN-1:0]   pipe_csr_rdata_o;
   logic [CSR_AW-1:0] csr_read_addr_o;
   logic              csr_read_enable_o;
   logic [XLEN-1:0]   csr_read_val_i;
   logic [CSR_AW-1:0] csr_write_addr_o;
   logic [XLEN-1:0]   csr_write_val_o;
   logic              csr_write_enable_o;
   logic              redirect_valid_o;
   logic [XLEN-1:0]   redirect_pc_o;
   logic              busy_o;

   modport slave (
      input  trap_req_i, trap_pc_i, trap_cause_i, trap_tval_i,
      input  mret_req_i,
      input  pipe_csr_req_i, pipe_csr_we_i, pipe_csr_raddr_i, pipe_csr_waddr_i, pipe_csr_wdata_i,
      input  csr_read_val_i,
      output trap_ack_o, mret_ack_o, pipe_csr_gnt_o, pipe_csr_rdata_o,
      output csr_read_addr_o, csr_read_enable_o,
      output csr_write_addr_o, csr_write_val_o, csr_write_enable_o,
      output redirect_valid_o, redirect_pc_o, busy_o
   );

   modport master (
      output trap_req_i, trap_pc_i, trap_cause_i, trap_tval_i,
      output mret_req_i,
      output pipe_csr_req_i, pipe_csr_we_i, pipe_csr_raddr_i, pipe_csr_waddr_i, pipe_csr_wdata_i,
      output csr_read_val_i,
      input  trap_ack_o, mret_ack_o, pipe_csr_gnt_o, pipe_csr_rdata_o,
      input  csr_read_addr_o, csr_read_enable_o,
      input  csr_write_addr_o, csr_write_val_o, csr_write_enable_o,
      input  redirect_valid_o, redirect_pc_o, busy_o
   );

endinterface

`default_nettype wire

// File: rtl/mod_trap_target_calc.sv
// mod_trap_target_calc: mtvec + cause -> trap target PC. TRAP_VECTORED_MTVEC_EN enables vectored interrupts.
// Rev 1.0
`default_nettype none

module mod_trap_target_calc
   import trap_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  wire logic [XLEN-1:0] i_mtvec,
   input  wire logic [XLEN-1:0] i_cause,
   output logic      [XLEN-1:0] o_target
);

   logic [XLEN-1:0] w_base;

   assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_MTVEC_EN
   localparam int unsigned c_INT_BIT = CAUSE_INT_BIT + XLEN - TRAP_XLEN;

   logic [XLEN-1:0] w_ofs;
   logic            w_unused;

   // cause[XLEN-2] shifts out of range; the offset wraps with the sum
   assign w_ofs    = {i_cause[XLEN-3:0], 2'b00};
   assign w_unused = i_cause[XLEN-2];
   assign o_target = ((i_mtvec[1:0] == 2'b01) && i_cause[c_INT_BIT]) ? (w_base + w_ofs) : w_base;
`else
   logic w_unused;

   assign w_unused = ^{i_mtvec[1:0], i_cause};
   assign o_target = w_base;
`endif

endmodule

`default_nettype wire

// File: rtl/mod_trap_sequencer.sv
// mod_trap_sequencer: sequences mepc/mcause/mtval writes and mtvec/mepc reads for trap entry and mret.
// Rev 1.0 -- vectored mtvec support via TRAP_VECTORED_MTVEC_EN (see mod_trap_target_calc).
`default_nettype none

module mod_trap_sequencer
   import trap_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
) (
   input  wire logic             clk_i,
   input  wire logic             rst_ni,
   mod_trap_sequencer_if.slave   bus
);

   localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
   localparam logic [2:0] S_W_EPC   = 3'(ST_W_EPC);
   localparam logic [2:0] S_W_CAUSE = 3'(ST_W_CAUSE);
   localparam logic [2:0] S_W_TVAL  = 3'(ST_W_TVAL);
   localparam logic [2:0] S_RD_TVEC = 3'(ST_RD_TVEC);
   localparam logic [2:0] S_RD_EPC  = 3'(ST_RD_EPC);

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [XLEN-1:2]   r_pc;
   logic [XLEN-1:0]   r_cause;
   logic [XLEN-1:0]   r_tval;
   logic              r_redirect_valid;
   logic [XLEN-1:0]   r_redirect_pc;
   logic [XLEN-1:0]   w_target;

   logic              w_trap_ack;
   logic              w_mret_ack;
   logic              w_gnt;
   logic              w_rd_en;
   logic [CSR_AW-1:0] w_rd_addr;
   logic              w_wr_en;
   logic [CSR_AW-1:0] w_wr_addr;
   logic [XLEN-1:0]   w_wr_val;
   logic              w_unused;

   assign w_unused = ^bus.trap_pc_i[1:0];

   mod_trap_target_calc #(
      .XLEN (XLEN)
   ) u_target_calc (
      .i_mtvec  (bus.csr_read_val_i),
      .i_cause  (r_cause),
      .o_target (w_target)
   );

   // Arbitration is gated by reset so no enable or grant escapes while rst_ni is low
   always_comb begin
      w_state_nxt = r_state;
      w_trap_ack  = 1'b0;
      w_mret_ack  = 1'b0;
      w_gnt       = 1'b0;
      w_rd_en     = 1'b0;
      w_rd_addr   = '0;
      w_wr_en     = 1'b0;
      w_wr_addr   = '0;
      w_wr_val    = '0;
      case (r_state)
         S_IDLE: begin
            if (rst_ni) begin
               if (bus.trap_req_i) begin
                  w_trap_ack  = 1'b1;
                  w_state_nxt = S_W_EPC;
               end else if (bus.mret_req_i) begin
                  w_mret_ack  = 1'b1;
                  w_state_nxt = S_RD_EPC;
               end else if (bus.pipe_csr_req_i) begin
                  w_gnt     = 1'b1;
                  w_rd_en   = 1'b1;
                  w_rd_addr = bus.pipe_csr_raddr_i;
                  if (bus.pipe_csr_we_i) begin
                     w_wr_en   = 1'b1;
                     w_wr_addr = bus.pipe_csr_waddr_i;
                     w_wr_val  = bus.pipe_csr_wdata_i;
                  end
               end
            end
         end
         S_W_EPC: begin
            w_wr_en     = 1'b1;
            w_wr_addr   = CSR_AW'(MEPC);
            w_wr_val    = {r_pc, 2'b00};
            w_state_nxt = S_W_CAUSE;
         end
         S_W_CAUSE: begin
            w_wr_en     = 1'b1;
            w_wr_addr   = CSR_AW'(MCAUSE);
            w_wr_val    = r_cause;
            w_state_nxt = S_W_TVAL;
         end
         S_W_TVAL: begin
            w_wr_en     = 1'b1;
            w_wr_addr   = CSR_AW'(MTVAL);
            w_wr_val    = r_tval;
            w_state_nxt = S_RD_TVEC;
         end
         S_RD_TVEC: begin
            w_rd_en     = 1'b1;
            w_rd_addr   = CSR_AW'(MTVEC);
            w_state_nxt = S_IDLE;
         end
         S_RD_EPC: begin
            w_rd_en     = 1'b1;
            w_rd_addr   = CSR_AW'(MEPC);
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state          <= S_IDLE;
         r_pc             <= '0;
         r_cause          <= '0;
         r_tval           <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_state          <= w_state_nxt;
         r_redirect_valid <= 1'b0;
         if (w_trap_ack) begin
            r_pc    <= bus.trap_pc_i[XLEN-1:2];
            r_cause <= bus.trap_cause_i;
            r_tval  <= bus.trap_tval_i;
         end
         if (r_state == S_RD_TVEC) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_target;
         end else if (r_state == S_RD_EPC) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= {bus.csr_read_val_i[XLEN-1:2], 2'b00};
         end
      end
   end

   assign bus.trap_ack_o         = w_trap_ack;
   assign bus.mret_ack_o         = w_mret_ack;
   assign bus.pipe_csr_gnt_o     = w_gnt;
   assign bus.pipe_csr_rdata_o   = w_gnt ? bus.csr_read_val_i : '0;
   assign bus.csr_read_addr_o    = w_rd_addr;
   assign bus.csr_read_enable_o  = w_rd_en;
   assign bus.csr_write_addr_o   = w_wr_addr;
   assign bus.csr_write_val_o    = w_wr_val;
   assign bus.csr_write_enable_o = w_wr_en;
   assign bus.redirect_valid_o   = r_redirect_valid;
   assign bus.redirect_pc_o      = r_redirect_pc;
   assign bus.busy_o             = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mod_trap_sequencer.sv
// tb_mod_trap_sequencer: scoreboard bench for the trap sequencer; the bench also models the CSR file.
// Rev 1.0
`default_nettype none

module tb_mod_trap_sequencer;

   logic clk;
   logic rst_n;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_wr[$];
   logic [31:0] exp_redir[$];

   int n_vec = 0;
   int n_mis = 0;

   logic [31:0] csr_mem [0:4095];
   logic        bd_we;
   logic [11:0] bd_addr;
   logic [31:0] bd_data;

`ifdef TRAP_VECTORED_MTVEC_EN
   localparam logic [31:0] c_VEC_TARGET = 32'h0000_901C;
`else
   localparam logic [31:0] c_VEC_TARGET = 32'h0000_9000;
`endif

   mod_trap_sequencer_if #(.XLEN(32), .CSR_AW(12)) bus ();

   mod_trap_sequencer #(.XLEN(32), .CSR_AW(12)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   assign bus.csr_read_val_i = csr_mem[bus.csr_read_addr_o];

   always @(posedge clk) begin
      if (bd_we)
         csr_mem[bd_addr] <= bd_data;
      else if (bus.csr_write_enable_o)
         csr_mem[bus.csr_write_addr_o] <= bus.csr_write_val_o;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.csr_write_enable_o) begin
            check_eq("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
               wr_t e;
               e = exp_wr.pop_front();
               check_eq("wr_addr", 32'(bus.csr_write_addr_o), 32'(e.addr));
               check_eq("wr_data", bus.csr_write_val_o, e.data);
            end
         end
         if (bus.redirect_valid_o) begin
            check_eq("redir_expected", 32'(exp_redir.size() != 0), 32'd1);
            if (exp_redir.size() != 0)
               check_eq("redir_pc", bus.redirect_pc_o, exp_redir.pop_front());
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bd_write(input logic [11:0] a, input logic [31:0] d);
      bd_addr = a;
      bd_data = d;
      bd_we   = 1'b1;
      tick();
      bd_we   = 1'b0;
   endtask

   // Leaves the bench at the negedge of the redirect cycle (cycle 5)
   task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] target);
      bus.trap_req_i   = 1'b1;
      bus.trap_pc_i    = pc;
      bus.trap_cause_i = cause;
      bus.trap_tval_i  = tval;
      exp_wr.push_back('{addr: 12'h341, data: {pc[31:2], 2'b00}});
      exp_wr.push_back('{addr: 12'h342, data: cause});
      exp_wr.push_back('{addr: 12'h343, data: tval});
      exp_redir.push_back(target);
      @(negedge clk);
      check_eq("trap_ack", 32'(bus.trap_ack_o), 32'd1);
      check_eq("trap_mret_ack0", 32'(bus.mret_ack_o), 32'd0);
      check_eq("trap_gnt0", 32'(bus.pipe_csr_gnt_o), 32'd0);
      tick();
      bus.trap_req_i = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check_eq("trap_busy", 32'(bus.busy_o), 32'd1);
         check_eq("trap_gnt_busy", 32'(bus.pipe_csr_gnt_o), 32'd0);
         check_eq("trap_mret_busy", 32'(bus.mret_ack_o), 32'd0);
         if (c == 4) begin
            check_eq("tvec_rd_en", 32'(bus.csr_read_enable_o), 32'd1);
            check_eq("tvec_rd_addr", 32'(bus.csr_read_addr_o), 32'h305);
         end
         tick();
      end
      @(negedge clk);
      check_eq("trap_redir_valid", 32'(bus.redirect_valid_o), 32'd1);
      check_eq("trap_busy_done", 32'(bus.busy_o), 32'd0);
   endtask

   task automatic do_mret(input logic [31:0] target);
      bus.mret_req_i = 1'b1;
      exp_redir.push_back(target);
      @(negedge clk);
      check_eq("mret_ack", 32'(bus.mret_ack_o), 32'd1);
      tick();
      bus.mret_req_i = 1'b0;
      @(negedge clk);
      check_eq("mret_rd_en", 32'(bus.csr_read_enable_o), 32'd1);
      check_eq("mret_rd_addr", 32'(bus.csr_read_addr_o), 32'h341);
      check_eq("mret_busy", 32'(bus.busy_o), 32'd1);
      tick();
      @(negedge clk);
      check_eq("mret_redir_valid", 32'(bus.redirect_valid_o), 32'd1);
      tick();
   endtask

   initial begin
      rst_n                = 1'b0;
      bd_we                = 1'b0;
      bd_addr              = '0;
      bd_data              = '0;
      bus.trap_req_i       = 1'b0;
      bus.trap_pc_i        = '0;
      bus.trap_cause_i     = '0;
      bus.trap_tval_i      = '0;
      bus.mret_req_i       = 1'b0;
      bus.pipe_csr_req_i   = 1'b0;
      bus.pipe_csr_we_i    = 1'b0;
      bus.pipe_csr_raddr_i = '0;
      bus.pipe_csr_waddr_i = '0;
      bus.pipe_csr_wdata_i = '0;

      bd_write(12'h305, 32'h0000_8000);
      bd_write(12'h000, 32'h0000_0000);
      @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
      check_eq("rst_redir_valid", 32'(bus.redirect_valid_o), 32'd0);
      check_eq("rst_redir_pc", bus.redirect_pc_o, 32'd0);
      check_eq("rst_wr_en", 32'(bus.csr_write_enable_o), 32'd0);
      check_eq("rst_rd_en", 32'(bus.csr_read_enable_o), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Basic trap, direct mtvec
      do_trap(32'h0000_1006, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0000_8000);
      tick();
      @(negedge clk);
      check_eq("redir_pulse_end", 32'(bus.redirect_valid_o), 32'd0);
      check_eq("redir_pc_held", bus.redirect_pc_o, 32'h0000_8000);
      tick();

      // mret
      bd_write(12'h341, 32'h0000_2000);
      do_mret(32'h0000_2000);

      // All three requesters at once
      bus.mret_req_i       = 1'b1;
      bus.pipe_csr_req_i   = 1'b1;
      bus.pipe_csr_we_i    = 1'b0;
      bus.pipe_csr_raddr_i = 12'h342;
      do_trap(32'h0000_3002, 32'h0000_0004, 32'h0000_0077, 32'h0000_8000);
      exp_redir.push_back(32'h0000_3000);
      check_eq("b2b_mret_ack", 32'(bus.mret_ack_o), 32'd1);
      check_eq("b2b_gnt0", 32'(bus.pipe_csr_gnt_o), 32'd0);
      tick();
      bus.mret_req_i = 1'b0;
      @(negedge clk);
      check_eq("b2b_epc_rd", 32'(bus.csr_read_addr_o), 32'h341);
      check_eq("b2b_gnt_rd", 32'(bus.pipe_csr_gnt_o), 32'd0);
      tick();
      @(negedge clk);
      check_eq("b2b_mret_redir", 32'(bus.redirect_valid_o), 32'd1);
      check_eq("b2b_gnt_last", 32'(bus.pipe_csr_gnt_o), 32'd1);
      check_eq("b2b_pipe_rdata", bus.pipe_csr_rdata_o, 32'h0000_0004);
      tick();
      bus.pipe_csr_req_i = 1'b0;

      // Pipeline write of vectored mtvec, then interrupt trap
      bus.pipe_csr_req_i   = 1'b1;
      bus.pipe_csr_we_i    = 1'b1;
      bus.pipe_csr_raddr_i = 12'h305;
      bus.pipe_csr_waddr_i = 12'h305;
      bus.pipe_csr_wdata_i = 32'h0000_9001;
      exp_wr.push_back('{addr: 12'h305, data: 32'h0000_9001});
      @(negedge clk);
      check_eq("pipe_gnt", 32'(bus.pipe_csr_gnt_o), 32'd1);
      check_eq("pipe_wr_en", 32'(bus.csr_write_enable_o), 32'd1);
      check_eq("pipe_rdata_old", bus.pipe_csr_rdata_o, 32'h0000_8000);
      tick();
      bus.pipe_csr_req_i = 1'b0;
      bus.pipe_csr_we_i  = 1'b0;
      do_trap(32'h0000_6000, 32'h8000_0007, 32'h0000_0011, c_VEC_TARGET);
      tick();

      // Reset while writing mcause
      bus.trap_req_i   = 1'b1;
      bus.trap_pc_i    = 32'h0000_5003;
      bus.trap_cause_i = 32'h0000_0001;
      bus.trap_tval_i  = 32'h0000_0000;
      exp_wr.push_back('{addr: 12'h341, data: 32'h0000_5000});
      @(negedge clk);
      check_eq("abort_ack", 32'(bus.trap_ack_o), 32'd1);
      tick();
      bus.trap_req_i = 1'b0;
      @(negedge clk);
      tick();
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", 32'(bus.busy_o), 32'd0);
      check_eq("abort_wr_en", 32'(bus.csr_write_enable_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("abort_no_redir", 32'(bus.redirect_valid_o), 32'd0);
         tick();
      end
      check_eq("abort_mepc_kept", csr_mem[12'h341], 32'h0000_5000);
      rst_n = 1'b1;
      tick();
      do_mret(32'h0000_5000);

      // Pipeline request held through a trap
      bus.pipe_csr_req_i   = 1'b1;
      bus.pipe_csr_we_i    = 1'b0;
      bus.pipe_csr_raddr_i = 12'h343;
      do_trap(32'h0000_7000, 32'h0000_0005, 32'hCAFE_0001, 32'h0000_9000);
      check_eq("held_gnt", 32'(bus.pipe_csr_gnt_o), 32'd1);
      check_eq("held_rdata", bus.pipe_csr_rdata_o, 32'hCAFE_0001);
      tick();
      bus.pipe_csr_req_i = 1'b0;

      tick();
      tick();
      check_eq("sb_wr_left", 32'(exp_wr.size()), 32'd0);
      check_eq("sb_redir_left", 32'(exp_redir.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mod_trap_sequencer.md
Name: mod_trap_sequencer

Overview:
- Controller that sequences the machine-mode CSR register file on trap entry and on `mret`.
- Owns the CSR file's single read port and single write port.
- Shares both ports with the pipeline's CSR-instruction access path.
- On a trap, writes mepc, mcause and mtval one per cycle, then reads mtvec and issues a PC redirect. On `mret`, reads mepc and issues a PC redirect.

Parameters:
- XLEN, 32, datapath/CSR width.
- CSR_AW, 12, CSR address width.

Ports:
- clk_i  in  1  single clock, all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- trap_req_i  in  1  trap request; held until acked.
- trap_pc_i  in  XLEN  faulting PC, destined for mepc.
- trap_cause_i  in  XLEN  cause (bit XLEN-1 = interrupt), destined for mcause.
- trap_tval_i  in  XLEN  destined for mtval.
- trap_ack_o  out  1  combinational accept; payload captured at this edge.
- mret_req_i  in  1  mret request; held until acked.
- mret_ack_o  out  1  combinational accept.
- pipe_csr_req_i  in  1  pipeline CSR access request.
- pipe_csr_we_i  in  1  pipeline write enable.
- pipe_csr_raddr_i  in  CSR_AW  pipeline read address.
- pipe_csr_waddr_i  in  CSR_AW  pipeline write address.
- pipe_csr_wdata_i  in  XLEN  pipeline write data.
- pipe_csr_gnt_o  out  1  combinational grant.
- pipe_csr_rdata_o  out  XLEN  read data, valid when granted.
- csr_read_addr_o  out  CSR_AW  to CSR file.
- csr_read_enable_o  out  1  to CSR file.
- csr_read_val_i  in  XLEN  combinational read data from CSR file.
- csr_write_addr_o  out  CSR_AW  to CSR file.
- csr_write_val_o  out  XLEN  to CSR file.
- csr_write_enable_o  out  1  to CSR file.
- redirect_valid_o  out  1  registered one-cycle pulse.
- redirect_pc_o  out  XLEN  registered target; held until the next redirect.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, RD_TVEC, RD_EPC.
- Reset (async, rst_ni low): state=IDLE; payload registers=0; redirect_valid_o=0; redirect_pc_o=0. All CSR enables deassert combinationally.
- Reset mid-sequence aborts it. Any CSR writes already issued stay in the CSR file; no redirect is emitted.
- IDLE arbitration, fixed priority trap > mret > pipeline:
  - trap_req_i: trap_ack_o=1; capture pc/cause/tval; next state W_EPC.
  - else mret_req_i: mret_ack_o=1; next state RD_EPC.
  - else pipe_csr_req_i: pipe_csr_gnt_o=1. CSR read and write ports pass through from the pipe_* signals (read_enable=1, write_enable=pipe_csr_we_i). pipe_csr_rdata_o=csr_read_val_i. Stay in IDLE.
- Outside IDLE: all acks and the grant are 0; requesters hold their requests.
- W_EPC: write addr 0x341, data = captured pc with bits[1:0] forced to 0. Next W_CAUSE.
- W_CAUSE: write addr 0x342, data = captured cause. Next W_TVAL.
- W_TVAL: write addr 0x343, data = captured tval. Next RD_TVEC.
- RD_TVEC: read addr 0x305, read_enable=1. At the edge, redirect_pc_o <= target(csr_read_val_i); redirect_valid_o <= 1. Next IDLE.
- RD_EPC: read addr 0x341, read_enable=1. At the edge, redirect_pc_o <= csr_read_val_i with bits[1:0] forced to 0; redirect_valid_o <= 1. Next IDLE.
- redirect_valid_o is 1 only in the cycle after RD_TVEC or RD_EPC; 0 otherwise.
- Latency, trap: ack at cycle 0, writes in cycles 1–3, read in cycle 4, redirect pulse in cycle 5.
- Latency, mret: ack at cycle 0, read in cycle 1, redirect pulse in cycle 2.
- A new request may be acked in the same cycle the redirect pulse is high (back-to-back allowed).
- Default target: {mtvec[XLEN-1:2], 2'b00}; mode bits ignored.
- When the CSR ports are idle, addresses and data drive 0.

Optional Feature:
- Macro: TRAP_VECTORED_MTVEC_EN.
- Defined: if mtvec[1:0]==2'b01 and cause[XLEN-1]==1, target = base + (cause[XLEN-2:0] << 2), where base = {mtvec[XLEN-1:2],2'b00}. Addition wraps modulo 2^XLEN. Otherwise target = base.
- Undefined: target = base always; vectored mode is treated as direct.

Decomposition:
- Shared package trap_pkg:
  - state enum trap_state_e.
  - CSR address constants MEPC/MCAUSE/MTVAL/MTVEC.
  - cause bit index constant CAUSE_INT_BIT.
- One sub-module: mod_trap_target_calc, combinational mtvec + cause -> target PC. The optional feature lives there.

Test Plan:
- Trap with pc=0x0000_1006, cause=0x2, tval=0xDEAD_BEEF, mtvec=0x0000_8000 -> writes over three cycles: 0x341=0x0000_1004, 0x342=0x2, 0x343=0xDEAD_BEEF. Redirect pulse at cycle 5 with pc=0x0000_8000. busy_o high in cycles 1–4.
- mret with mepc=0x0000_2000 -> read of 0x341 at cycle 1; redirect_pc_o=0x0000_2000 pulses at cycle 2.
- trap_req, mret_req and pipe_csr_req all high in IDLE -> only trap_ack_o=1. mret is acked in the cycle after RD_TVEC; the pipeline is granted only once both are done.
- Pipeline write to 0x305 of 0x0000_9001 while idle -> gnt=1, CSR write passthrough in the same cycle. A following trap with cause=0x8000_0007 redirects to 0x0000_901C (feature on) or 0x0000_9000 (feature off).
- rst_ni asserted during W_CAUSE -> immediately state=IDLE, write_enable=0, no redirect pulse. mepc retains the written value.
- Pipeline request held during a trap sequence -> gnt=0 for cycles 1–4, gnt=1 in cycle 5.
